// File: rtl/riser_bus_pkg.sv
// Shared types for the riser 68020-style bus initiator:
// FSM states, DSACK encodings and the error read value.
package riser_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ASTB,
    DSTB,
    WAIT,
    NEGATE,
    RECOVER,
    FIN
  } state_t;

  localparam logic [1:0] DSACK_NONE = 2'b11;
  localparam logic [1:0] DSACK_BYTE = 2'b10;
  localparam logic [1:0] DSACK_WORD = 2'b01;
  localparam logic [1:0] DSACK_LONG = 2'b00;

  localparam logic [7:0] RDATA_ERR = 8'hFF;

endpackage

// File: rtl/cpu_bus_initiator_dsack_sync.sv
// Two-flop synchroniser for the asynchronous DSACK pair.
// Resets to the idle (no acknowledge) encoding.
module dsack_sync
  import riser_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] d,
  output logic [1:0] q
);

  logic [1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= DSACK_NONE;
      q    <= DSACK_NONE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cpu_bus_initiator.sv
// Byte-wide 68020-style async bus master with a REQ/DONE front end.
// Optional abort on a stuck DSACK when BUS_TIMEOUT_EN is defined.
module cpu_bus_initiator
  import riser_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        CLKCPU_A,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        REQ_RW,
  input  logic [23:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  RDATA,
  output logic        AS20,
  output logic        DS20,
  output logic        RW,
  output logic [23:0] A,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  input  logic [7:0]  D_IN,
  input  logic [1:0]  DSACK
);

  if (TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_to_w_check
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end

  state_t     state;
  state_t     nxt;
  logic [1:0] dsack_s;
  logic       ack;
  logic       rel;
  logic       wr;

  dsack_sync u_sync (
    .clk (CLKCPU_A),
    .rst (RESET),
    .d   (DSACK),
    .q   (dsack_s)
  );

  assign ack = dsack_s != DSACK_NONE;
  assign rel = dsack_s == DSACK_NONE;
  // Direction of the cycle being set up: live request in IDLE, latched after.
  assign wr  = (state == IDLE) ? !REQ_RW : !RW;

`ifdef BUS_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt;
  logic            to_hit;

  assign to_hit = cnt == TO_LAST;

  always_ff @(posedge CLKCPU_A) begin
    if (RESET) begin
      cnt <= '0;
    end else if (state inside {DSTB, NEGATE}) begin
      cnt <= '0;
    end else if (state inside {WAIT, RECOVER}) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge CLKCPU_A) begin
    if (RESET) begin
      ERR <= 1'b0;
    end else if (state == WAIT) begin
      if (ack) begin
        ERR <= 1'b0;
      end else if (to_hit) begin
        ERR <= 1'b1;
      end
    end else if (state == RECOVER && !rel && to_hit) begin
      ERR <= 1'b1;
    end
  end
`else
  assign ERR = 1'b0;
`endif

  always_ff @(posedge CLKCPU_A) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (REQ) begin
          nxt = ADDR;
        end
      end
      ADDR:   nxt = ASTB;
      ASTB:   nxt = DSTB;
      DSTB:   nxt = WAIT;
      WAIT: begin
        if (ack) begin
          nxt = NEGATE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (to_hit) begin
          nxt = NEGATE;
        end
`endif
      end
      NEGATE: nxt = RECOVER;
      RECOVER: begin
        if (rel) begin
          nxt = FIN;
        end
`ifdef BUS_TIMEOUT_EN
        else if (to_hit) begin
          nxt = FIN;
        end
`endif
      end
      FIN:    nxt = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so each pin
  // changes on the same edge the FSM enters the matching state.
  always_ff @(posedge CLKCPU_A) begin
    if (RESET) begin
      AS20  <= 1'b1;
      DS20  <= 1'b1;
      RW    <= 1'b1;
      A     <= '0;
      D_OUT <= '0;
      D_OE  <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      RDATA <= RDATA_ERR;
    end else begin
      BUSY <= nxt != IDLE;
      DONE <= nxt == FIN;
      AS20 <= !(nxt inside {ASTB, DSTB, WAIT});
      DS20 <= !(nxt inside {DSTB, WAIT});
      D_OE <= wr && (nxt inside {ADDR, ASTB, DSTB, WAIT, NEGATE});
      if (state == IDLE && REQ) begin
        A  <= REQ_ADDR;
        RW <= REQ_RW;
        if (!REQ_RW) begin
          D_OUT <= REQ_WDATA;
        end
      end
      if (state == WAIT) begin
        if (ack) begin
          if (RW) begin
            RDATA <= D_IN;
          end
        end
`ifdef BUS_TIMEOUT_EN
        else if (to_hit) begin
          RDATA <= RDATA_ERR;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_initiator.sv
// Scoreboard bench for cpu_bus_initiator with a DSACK responder model.
`timescale 1ns/1ps
module tb_cpu_bus_initiator;

  localparam int TO_T = 16;

  logic        clk = 1'b0;
  logic        RESET;
  logic        REQ;
  logic        REQ_RW;
  logic [23:0] REQ_ADDR;
  logic [7:0]  REQ_WDATA;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [7:0]  RDATA;
  logic        AS20;
  logic        DS20;
  logic        RW;
  logic [23:0] A;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic [7:0]  D_IN;
  logic [1:0]  DSACK;

  always #5 clk = ~clk;

  cpu_bus_initiator #(
    .TIMEOUT_CYCLES (TO_T),
    .TO_W           (8)
  ) dut (
    .CLKCPU_A  (clk),
    .RESET     (RESET),
    .REQ       (REQ),
    .REQ_RW    (REQ_RW),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR),
    .RDATA     (RDATA),
    .AS20      (AS20),
    .DS20      (DS20),
    .RW        (RW),
    .A         (A),
    .D_OUT     (D_OUT),
    .D_OE      (D_OE),
    .D_IN      (D_IN),
    .DSACK     (DSACK)
  );

  typedef struct {
    bit          rw;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    bit          err;
    int          done_cyc;
  } exp_t;

  exp_t       sb[$];
  int         as_falls[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ds_cnt = 0;
  int         dly = 0;
  logic [1:0] code = 2'b10;
  logic [7:0] rbyte = 8'h00;
  logic [7:0] model_rdata = 8'hFF;

  // Responder: acknowledges dly cycles after DS20 falls, releases with DS20.
  always @(posedge clk) ds_cnt <= DS20 ? 0 : ds_cnt + 1;
  assign DSACK = (DS20 === 1'b0 && ds_cnt >= dly) ? code : 2'b11;
  assign D_IN  = rbyte;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic exp_t predict(bit rw, logic [23:0] addr,
                                   logic [7:0] wd, logic [7:0] rb,
                                   int d, int c0);
    exp_t x;
    bit   to = 1'b0;
`ifdef BUS_TIMEOUT_EN
    to = (d + 2 > TO_T);
`endif
    x.rw    = rw;
    x.addr  = addr;
    x.wdata = wd;
    if (to) begin
      x.rdata    = 8'hFF;
      x.err      = 1'b1;
      x.done_cyc = c0 + 5 + TO_T;
    end else begin
      x.rdata    = rw ? rb : model_rdata;
      x.err      = 1'b0;
      x.done_cyc = c0 + 8 + d;
    end
    model_rdata = x.rdata;
    return x;
  endfunction

  // Monitor: observes bus and pops the scoreboard on every DONE.
  logic        as_prev = 1'b1;
  bit          oe_seen = 1'b0;
  bit          cap_v = 1'b0;
  logic [23:0] cap_a;
  logic        cap_rw;
  logic        cap_oe;
  logic [7:0]  cap_d;

  always @(negedge clk) begin
    exp_t e;
    if (RESET) begin
      oe_seen = 1'b0;
      cap_v   = 1'b0;
      as_prev = 1'b1;
    end else begin
      if (D_OE) oe_seen = 1'b1;
      if (as_prev && !AS20) as_falls.push_back(cyc);
      as_prev = AS20;
      if (!DS20 && DSACK != 2'b11) begin
        cap_a  = A;
        cap_rw = RW;
        cap_d  = D_OUT;
        cap_oe = D_OE;
        cap_v  = 1'b1;
      end
      if (DONE) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("rdata", RDATA, e.rdata);
          chk("err", ERR, e.err);
          chk("oe_seen", oe_seen, !e.rw);
          chk("addr_held", A, e.addr);
          chk("rw_held", RW, e.rw);
          if (!e.err) begin
            chk("ack_seen", cap_v, 1);
            chk("bus_addr", cap_a, e.addr);
            chk("bus_rw", cap_rw, e.rw);
            chk("bus_oe", cap_oe, !e.rw);
            if (!e.rw) chk("bus_wdata", cap_d, e.wdata);
          end
        end
        oe_seen = 1'b0;
        cap_v   = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (BUSY) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        checks++;
        errors++;
        $display("FAIL idle_wait timed out");
        return;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 || BUSY) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        checks++;
        errors++;
        $display("FAIL drain timed out, %0d pending", sb.size());
        return;
      end
    end
  endtask

  task automatic issue(bit rw, logic [23:0] addr, logic [7:0] wd,
                       logic [7:0] rb, int d, logic [1:0] c, bit track);
    wait_idle();
    REQ_RW    = rw;
    REQ_ADDR  = addr;
    REQ_WDATA = wd;
    rbyte     = rb;
    dly       = d;
    code      = c;
    REQ       = 1'b1;
    if (track) sb.push_back(predict(rw, addr, wd, rb, d, cyc + 1));
    @(negedge clk);
    REQ = 1'b0;
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    model_rdata = 8'hFF;
  endtask

  initial begin
    int c0;
    int n;
    logic [1:0] codes [3];
    codes[0] = 2'b10;
    codes[1] = 2'b01;
    codes[2] = 2'b00;

    RESET = 1'b1;
    REQ = 1'b0;
    REQ_RW = 1'b1;
    REQ_ADDR = '0;
    REQ_WDATA = '0;
    repeat (3) @(negedge clk);
    chk("rst_as", AS20, 1);
    chk("rst_ds", DS20, 1);
    chk("rst_rw", RW, 1);
    chk("rst_a", A, 0);
    chk("rst_dout", D_OUT, 0);
    chk("rst_oe", D_OE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_rdata", RDATA, 8'hFF);
    RESET = 1'b0;
    @(negedge clk);

    issue(1'b1, 24'hBFE001, 8'h00, 8'h3C, 0, 2'b10, 1'b1);
    drain();
    issue(1'b0, 24'hDFF034, 8'hA5, 8'h00, 20, 2'b10, 1'b1);
    drain();
    issue(1'b1, 24'hDFF00A, 8'h00, 8'h81, 0, 2'b00, 1'b1);
    drain();

    wait_idle();
    as_falls.delete();
    REQ_RW = 1'b1;
    REQ_ADDR = 24'hBFD100;
    rbyte = 8'h5E;
    dly = 0;
    code = 2'b10;
    REQ = 1'b1;
    c0 = cyc + 1;
    sb.push_back(predict(1'b1, 24'hBFD100, 8'h00, 8'h5E, 0, c0));
    sb.push_back(predict(1'b1, 24'hBFD100, 8'h00, 8'h5E, 0, c0 + 10));
    while (cyc < c0 + 10) @(negedge clk);
    REQ = 1'b0;
    drain();
    chk("b2b_count", as_falls.size(), 2);
    if (as_falls.size() == 2) chk("b2b_spacing", as_falls[1] - as_falls[0], 10);

    as_falls.delete();
    issue(1'b1, 24'hBFE301, 8'h00, 8'h96, 3, 2'b01, 1'b1);
    @(negedge clk);
    REQ = 1'b1;
    repeat (4) @(negedge clk);
    REQ = 1'b0;
    drain();
    chk("busy_req_ignored", as_falls.size(), 1);

    issue(1'b0, 24'hDFF040, 8'h3A, 8'h00, 20, 2'b10, 1'b0);
    n = 0;
    while (DS20 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_reached_wait", DS20, 0);
    repeat (3) @(negedge clk);
    pulse_reset();
    chk("midrst_as", AS20, 1);
    chk("midrst_ds", DS20, 1);
    chk("midrst_oe", D_OE, 0);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_done", DONE, 0);
    repeat (30) @(negedge clk);
    issue(1'b1, 24'hBFE201, 8'h00, 8'hC3, 1, 2'b10, 1'b1);
    drain();

`ifdef BUS_TIMEOUT_EN
    issue(1'b1, 24'hBFEC01, 8'h00, 8'h77, 1 << 20, 2'b10, 1'b1);
    drain();
`else
    issue(1'b1, 24'hBFEC01, 8'h00, 8'h77, 1 << 20, 2'b10, 1'b0);
    repeat (1000) @(negedge clk);
    chk("stuck_busy", BUSY, 1);
    pulse_reset();
    chk("stuck_rst_busy", BUSY, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      issue(1'($urandom_range(0, 1)), 24'($urandom), 8'($urandom),
            8'($urandom), int'($urandom_range(0, 6)),
            codes[$urandom_range(0, 2)], 1'b1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
